au_sub_v_ser: RTL and testbench

AU_SUB_V_SER -- requirements
Module: au_sub_v_ser

---
 rtl/au_sub_v_ser.sv | 145 ++++++++++++++
 tb/tb_au_sub_v_ser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_sub_v_ser.sv
// au_sub_v_ser: digit-serial subtractor computing d = a - b - bi, DIGIT bits per cycle.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset
//   start  - launch request, accepted while idle or in the done cycle
//   a, b   - minuend / subtrahend, captured on the launching edge
//   bi     - borrow-in, captured on the launching edge
//   busy   - operation in progress
//   done   - one-cycle completion pulse; d, bo, v valid from this cycle
//   d      - difference modulo 2^WIDTH
//   bo     - borrow-out (unsigned a < b + bi)
//   v      - two's-complement overflow of a - b - bi
module au_sub_v_ser #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             v
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             bo_q, bo_d;
  logic             v_q, v_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] slice_diff;
  logic             slice_bout;
  logic             slice_msb_bin;
  logic             ready;
  logic             launch;
  logic             last_digit;

  // Ripple-borrow subtract of the current low slice. The borrow entering the
  // slice's top bit is kept: on the final slice that bit is the MSB, and
  // borrow-into-MSB XOR borrow-out-of-MSB equals the carry-based overflow.
  always_comb begin : slice_sub
    logic chain;
    chain         = borrow_q;
    slice_diff    = '0;
    slice_msb_bin = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_diff[i] = a_q[i] ^ b_q[i] ^ chain;
      slice_msb_bin = chain;
      chain         = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & chain);
    end
    slice_bout = chain;
  end

  always_comb begin
    ready      = (state_q == IDLE) || (state_q == DONE);
    launch     = ready && start;
    last_digit = (cnt_q == LAST);

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
    v_d      = v_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (launch) begin
      a_d      = a;
      b_d      = b;
      borrow_d = bi;
      cnt_d    = '0;
      res_d    = '0;
    end else if (state_q == RUN) begin
      // Operands shift right so the active slice is always at bit 0; the
      // difference fills the accumulator from the top, ending LSB-aligned.
      a_d      = a_q >> DIGIT;
      b_d      = b_q >> DIGIT;
      borrow_d = slice_bout;
      res_d    = (res_q >> DIGIT) | (WIDTH'(slice_diff) << (WIDTH - DIGIT));
      cnt_d    = cnt_q + CW'(1);
      if (last_digit) begin
        cnt_d = '0;
        d_d   = res_d;
        bo_d  = slice_bout;
        v_d   = slice_msb_bin ^ slice_bout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      v_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;
  assign v    = v_q;

endmodule

// File: tb/tb_au_sub_v_ser.sv
// Bench for au_sub_v_ser: four WIDTH=8 instances with DIGIT = 1, 2, 4, 8.
// Expected results come from an arithmetic model and flow through a scoreboard queue.
module tb_au_sub_v_ser;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       v;
    int         n;
    int         t0;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_s [4];
  logic [7:0] a_s     [4];
  logic [7:0] b_s     [4];
  logic       bi_s    [4];
  logic       busy_s  [4];
  logic       done_s  [4];
  logic [7:0] d_s     [4];
  logic       bo_s    [4];
  logic       v_s     [4];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    au_sub_v_ser #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_s[g]),
      .a     (a_s[g]),
      .b     (b_s[g]),
      .bi    (bi_s[g]),
      .busy  (busy_s[g]),
      .done  (done_s[g]),
      .d     (d_s[g]),
      .bo    (bo_s[g]),
      .v     (v_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int g, input logic [7:0] a, input logic [7:0] b,
                                 input logic bi);
    exp_t e;
    logic [8:0] full;
    int sa, sbv, sr;
    full = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    sa   = a[7] ? int'(a) - 256 : int'(a);
    sbv  = b[7] ? int'(b) - 256 : int'(b);
    sr   = sa - sbv - int'(bi);
    e.d  = full[7:0];
    e.bo = full[8];
    e.v  = (sr > 127) || (sr < -128);
    e.n  = 8 >> g;
    e.t0 = 0;
    return e;
  endfunction

  // Drive a launch request; returns 1ns after the sampling edge with inputs scrambled.
  task automatic do_launch(input int g, input logic [7:0] a, input logic [7:0] b,
                           input logic bi);
    exp_t e;
    e = model(g, a, b, bi);
    a_s[g] = a; b_s[g] = b; bi_s[g] = bi; start_s[g] = 1'b1;
    @(posedge clk); #1;
    e.t0 = cyc;
    sb.push_back(e);
    start_s[g] = 1'b0;
    a_s[g] = 8'($urandom); b_s[g] = 8'($urandom); bi_s[g] = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done and hand back observed and expected values; returns at
  // the falling edge inside the done cycle.
  task automatic collect(input int g, output bit got, output logic [9:0] obs,
                         output logic [9:0] expv, output int lat, output int n);
    exp_t e;
    got = 1'b0; expv = '0; lat = -1; n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done_s[g] === 1'b1) begin got = 1'b1; break; end
    end
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      expv = {e.d, e.bo, e.v};
      n    = e.n;
      if (got) lat = cyc - e.t0;
    end
    obs = {d_s[g], bo_s[g], v_s[g]};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      start_s[g] = 1'b1; a_s[g] = 8'h5A; b_s[g] = 8'h3C; bi_s[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      total++;
      if ({busy_s[g], done_s[g], d_s[g], bo_s[g], v_s[g]} !== 12'h000) begin
        bad++;
        $display("FAIL reset_state[%0d] got=%h want=000", g,
                 {busy_s[g], done_s[g], d_s[g], bo_s[g], v_s[g]});
      end
    end
    for (int g = 0; g < 4; g++) start_s[g] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy_s[2] !== 1'b0) begin
      bad++; $display("FAIL reset_no_launch busy=%b want=0", busy_s[2]);
    end
  endtask

  task automatic test_basic;
    logic [16:0] vec [3];
    bit got; logic [9:0] obs, expv; int lat, n;
    vec[0] = {8'h00, 8'h01, 1'b0};
    vec[1] = {8'h80, 8'h01, 1'b0};
    vec[2] = {8'h7F, 8'hFF, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_launch(2, vec[i][16:9], vec[i][8:1], vec[i][0]);
      collect(2, got, obs, expv, lat, n);
      total++;
      if (!got) begin bad++; $display("FAIL basic_done[%0d] got=0 want=1", i); end
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL basic_result[%0d] got=%h want=%h", i, obs, expv);
      end
      total++;
      if (lat != n) begin bad++; $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, lat, n); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_busy;
    bit got; logic [9:0] obs, expv; int lat, n;
    do_launch(2, 8'h05, 8'h03, 1'b1);
    start_s[2] = 1'b1; a_s[2] = 8'h10; b_s[2] = 8'h20; bi_s[2] = 1'b0;
    @(negedge clk);
    total++;
    if (busy_s[2] !== 1'b1) begin bad++; $display("FAIL ignore_busy busy=%b want=1", busy_s[2]); end
    @(posedge clk); #1;
    start_s[2] = 1'b0;
    collect(2, got, obs, expv, lat, n);
    total++;
    if (!got || obs !== expv || lat != n) begin
      bad++; $display("FAIL ignore_result got=%h/%0d want=%h/%0d", obs, lat, expv, n);
    end
    @(negedge clk);
    total++;
    if ({busy_s[2], d_s[2], bo_s[2], v_s[2]} !== {1'b0, 8'h01, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ignore_after got=%h want=%h",
                      {busy_s[2], d_s[2], bo_s[2], v_s[2]}, {1'b0, 8'h01, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    bit got; logic [9:0] obs, expv, first; int lat, n;
    @(posedge clk); #1;
    do_launch(2, 8'h34, 8'h12, 1'b0);
    collect(2, got, obs, expv, lat, n);
    first = expv;
    total++;
    if (!got || obs !== expv) begin
      bad++; $display("FAIL b2b_first got=%h want=%h", obs, expv);
    end
    do_launch(2, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    total++;
    if ({busy_s[2], done_s[2]} !== 2'b10) begin
      bad++; $display("FAIL b2b_busy got=%b want=10", {busy_s[2], done_s[2]});
    end
    total++;
    if ({d_s[2], bo_s[2], v_s[2]} !== first) begin
      bad++; $display("FAIL b2b_hold got=%h want=%h", {d_s[2], bo_s[2], v_s[2]}, first);
    end
    collect(2, got, obs, expv, lat, n);
    total++;
    if (!got || obs !== expv) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", obs, expv);
    end
    total++;
    if (lat != 2) begin bad++; $display("FAIL b2b_latency got=%0d want=2", lat); end
  endtask

  task automatic test_rst_abort;
    bit got, seen; logic [9:0] obs, expv; int lat, n;
    exp_t e;
    @(posedge clk); #1;
    do_launch(2, 8'h55, 8'h11, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    e = sb.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_s[2] !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
    total++;
    if ({busy_s[2], d_s[2], bo_s[2], v_s[2]} !== 11'h000) begin
      bad++; $display("FAIL abort_outputs got=%h want=000", {busy_s[2], d_s[2], bo_s[2], v_s[2]});
    end
    do_launch(2, 8'hA0, 8'h0B, 1'b1);
    collect(2, got, obs, expv, lat, n);
    total++;
    if (!got || obs !== expv || lat != n) begin
      bad++; $display("FAIL abort_recover got=%h/%0d want=%h/%0d", obs, lat, expv, n);
    end
  endtask

  task automatic test_sweep;
    bit got; logic [9:0] obs, expv; int lat, n;
    logic [16:0] corner [8];
    logic [16:0] op;
    corner[0] = {8'h00, 8'h00, 1'b0}; corner[1] = {8'h00, 8'h01, 1'b0};
    corner[2] = {8'h80, 8'h01, 1'b0}; corner[3] = {8'h7F, 8'hFF, 1'b0};
    corner[4] = {8'hFF, 8'hFF, 1'b1}; corner[5] = {8'h00, 8'hFF, 1'b1};
    corner[6] = {8'h80, 8'h7F, 1'b1}; corner[7] = {8'h7F, 8'h80, 1'b0};
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 408; k++) begin
        op = (k < 8) ? corner[k] : 17'($urandom);
        do_launch(g, op[16:9], op[8:1], op[0]);
        collect(g, got, obs, expv, lat, n);
        total++;
        if (!got || obs !== expv) begin
          bad++;
          $display("FAIL sweep_result[D%0d] a=%h b=%h bi=%b got=%h want=%h",
                   1 << g, op[16:9], op[8:1], op[0], obs, expv);
        end
        total++;
        if (lat != n) begin
          bad++; $display("FAIL sweep_latency[D%0d] got=%0d want=%0d", 1 << g, lat, n);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      start_s[g] = 1'b0; a_s[g] = '0; b_s[g] = '0; bi_s[g] = 1'b0;
    end
    test_reset;
    test_basic;
    test_ignore_busy;
    test_back_to_back;
    test_rst_abort;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
